// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl
//   Streams one softmax vector (up to N_MAX elements) through a shared exp
//   unit: buffers the scores while tracking the maximum, issues clamped
//   (x - max) operands one per cycle, captures exp results and accumulates
//   the denominator, then streams results and the sum downstream.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     score input handshake
//   in_data[16:0]         score, sign-magnitude {sign, int[3:0], frac[11:0]}
//   in_last               last score of the vector
//   exp_x[16:0]           registered operand to the exp unit
//   exp_y[20:0]           exp unit result {pos[4:0], mant[15:0]}
//   out_valid/out_ready   result output handshake
//   out_data[20:0]        exp result, input order
//   out_last              last result of the vector
//   sum_valid             one-cycle pulse after the final result handshake
//   sum_data[ACC_W-1:0]   sum of (mant << min(pos,16)); held until next sum
//   busy                  controller not idle
//   sat_cnt               clamped-element count (only with SOFTMAX_SEQ_SAT_CNT_EN)
//
// Optional build macro: SOFTMAX_SEQ_SAT_CNT_EN adds the sat_cnt output.
module softmax_seq_ctrl #(
  parameter int N_MAX   = 16,
  parameter int EXP_LAT = 1,
  parameter int ACC_W   = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [16:0]              in_data,
  input  logic                     in_last,
  output logic [16:0]              exp_x,
  input  logic [20:0]              exp_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [20:0]              out_data,
  output logic                     out_last,
  output logic                     sum_valid,
  output logic [ACC_W-1:0]         sum_data,
  output logic                     busy
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
  ,
  output logic [$clog2(N_MAX):0]   sat_cnt
`endif
);

  localparam int IW = $clog2(N_MAX);
  localparam int LW = IW + 1;
  localparam logic signed [17:0] CLAMP_MIN = -18'sd40960;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN} state_t;

  // Sign-magnitude to two's complement; -0 maps to 0 so it compares equal to +0.
  function automatic logic signed [17:0] sm_to_s(input logic [16:0] x);
    logic signed [17:0] m;
    m = $signed({2'b00, x[15:0]});
    return x[16] ? -m : m;
  endfunction

  function automatic logic signed [17:0] clamp_d(input logic signed [17:0] d);
    return (d < CLAMP_MIN) ? CLAMP_MIN : d;
  endfunction

  // Zero always leaves as 0x00000, never as negative zero.
  function automatic logic [16:0] s_to_sm(input logic signed [17:0] d);
    logic signed [17:0] n;
    n = -d;
    return (d < 18'sd0) ? {1'b1, n[15:0]} : {1'b0, d[15:0]};
  endfunction

  function automatic logic [31:0] exp_term(input logic [20:0] y);
    logic [4:0] sh;
    sh = (y[20:16] > 5'd16) ? 5'd16 : y[20:16];
    return {16'h0000, y[15:0]} << sh;
  endfunction

  state_t             state_q, state_d;
  logic               rdy_q;
  logic [IW-1:0]      cnt_q, cnt_d, cap_q, cap_d, drn_q, drn_d;
  logic [LW-1:0]      len_q, len_d, iss_q, iss_d;
  logic signed [17:0] max_q, max_d;
  logic [ACC_W-1:0]   acc_q, acc_d, sum_data_q, sum_data_d;
  logic [16:0]        exp_x_q, exp_x_d;
  logic               sum_valid_q, sum_valid_d;
  logic [EXP_LAT:0]   vld_q, vld_d;
  logic [16:0]        sbuf_q [N_MAX];
  logic [20:0]        rbuf_q [N_MAX];
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
  logic [LW-1:0]      sat_q, sat_d;
`endif

  logic               in_fire, out_fire, wr_en, cap_en, issue_fire, last_out, clamp_hit;
  logic [IW-1:0]      wr_idx;
  logic signed [17:0] in_val, raw_d;

  assign in_ready  = rdy_q && (state_q == S_IDLE || state_q == S_LOAD);
  assign in_fire   = in_valid && in_ready;
  assign in_val    = sm_to_s(in_data);
  assign raw_d     = sm_to_s(sbuf_q[iss_q[IW-1:0]]) - max_q;
  assign clamp_hit = raw_d < CLAMP_MIN;
  assign cap_en    = vld_q[EXP_LAT];
  assign last_out  = ({1'b0, drn_q} == len_q - LW'(1));
  assign out_valid = (state_q == S_DRAIN);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = rbuf_q[drn_q];
  assign out_last  = out_valid && last_out;
  assign busy      = (state_q != S_IDLE);
  assign exp_x     = exp_x_q;
  assign sum_valid = sum_valid_q;
  assign sum_data  = sum_data_q;
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
  assign sat_cnt   = sat_q;
`endif

  // Issue tag delayed to the cycle in which exp_y belongs to that issue.
  if (EXP_LAT == 0) begin : g_lat0
    assign vld_d = issue_fire;
  end else begin : g_latn
    assign vld_d = {vld_q[EXP_LAT-1:0], issue_fire};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    drn_d       = drn_q;
    max_d       = max_q;
    acc_d       = acc_q;
    exp_x_d     = exp_x_q;
    sum_valid_d = 1'b0;
    sum_data_d  = sum_data_q;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    issue_fire  = 1'b0;
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          wr_en  = 1'b1;
          wr_idx = '0;
          max_d  = in_val;
          acc_d  = '0;
          cnt_d  = IW'(1);
          iss_d  = '0;
          cap_d  = '0;
          drn_d  = '0;
          len_d  = LW'(1);
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
          sat_d  = '0;
`endif
          state_d = in_last ? S_ISSUE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          wr_en = 1'b1;
          if (in_val > max_q) max_d = in_val;
          cnt_d = cnt_q + IW'(1);
          if (in_last || cnt_q == IW'(N_MAX - 1)) begin
            len_d   = {1'b0, cnt_q} + LW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (iss_q != len_q) begin
          issue_fire = 1'b1;
          exp_x_d    = s_to_sm(clamp_d(raw_d));
          iss_d      = iss_q + LW'(1);
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
          sat_d      = sat_q + LW'(clamp_hit);
`endif
        end
        if (cap_en) begin
          acc_d = acc_q + ACC_W'(exp_term(exp_y));
          cap_d = cap_q + IW'(1);
          if ({1'b0, cap_q} == len_q - LW'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          drn_d = drn_q + IW'(1);
          if (last_out) begin
            sum_valid_d = 1'b1;
            sum_data_d  = acc_q;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      drn_q       <= '0;
      max_q       <= '0;
      acc_q       <= '0;
      exp_x_q     <= '0;
      vld_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
      sat_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      drn_q       <= drn_d;
      max_q       <= max_d;
      acc_q       <= acc_d;
      exp_x_q     <= exp_x_d;
      vld_q       <= vld_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  // Score and result buffers carry data only; no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) sbuf_q[wr_idx] <= in_data;
    if (cap_en && state_q == S_ISSUE) rbuf_q[cap_q] <= exp_y;
  end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
module tb_softmax_seq_ctrl;
  localparam int N_MAX   = 16;
  localparam int EXP_LAT = 1;
  localparam int ACC_W   = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic [16:0]      in_data = '0;
  logic [20:0]      exp_y = '0;
  logic             in_ready, out_valid, out_last, sum_valid, busy;
  logic [16:0]      exp_x;
  logic [20:0]      out_data;
  logic [ACC_W-1:0] sum_data;
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
  logic [$clog2(N_MAX):0] sat_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [16:0] ex_x [N_MAX];

  typedef struct {
    int          n;
    int          stall;
    int          sat;
    logic [16:0] din [4];
    logic [16:0] ex  [4];
  } vec_t;
  vec_t tab [8];

  softmax_seq_ctrl #(.N_MAX(N_MAX), .EXP_LAT(EXP_LAT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .exp_x(exp_x), .exp_y(exp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sum_valid(sum_valid), .sum_data(sum_data), .busy(busy)
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in exp unit: deterministic tag of the operand, one cycle latency.
  function automatic logic [20:0] exp_f(input logic [16:0] x);
    logic [4:0] p;
    p = x[16] ? {1'b0, x[15:12]} : 5'd20;
    return {p, x[15:0] ^ 16'h9ABC};
  endfunction

  always @(posedge clk) exp_y <= exp_f(exp_x);

  function automatic longint ref_term(input logic [20:0] y);
    int sh;
    sh = int'(y[20:16]);
    if (sh > 16) sh = 16;
    return longint'(y[15:0]) * (longint'(1) << sh);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [16:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_issue(input int n);
    bit rdy_bad;
    rdy_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("exp_x[%0d]", i), exp_x, ex_x[i]);
      if (in_ready) rdy_bad = 1'b1;
    end
    check("in_ready_issue", rdy_bad, 0);
  endtask

  task automatic drain_check(input int n, input int stall, input int sat);
    int     t;
    bit     rdy_bad, sv_early;
    longint esum;
    t = 0; rdy_bad = 1'b0; sv_early = 1'b0; esum = 0;
    out_ready = 1'b0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain_start", out_valid, 1);
    for (int s = 0; s < stall; s++) begin
      check($sformatf("stall_hold[%0d]", s), {out_valid, out_data}, {1'b1, exp_f(ex_x[0])});
      if (sum_valid) sv_early = 1'b1;
      if (in_ready) rdy_bad = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      esum += ref_term(exp_f(ex_x[i]));
      out_ready = 1'b1;
      check($sformatf("out_data[%0d]", i), {out_valid, out_data}, {1'b1, exp_f(ex_x[i])});
      check($sformatf("out_last[%0d]", i), out_last, (i == n - 1));
      if (sum_valid) sv_early = 1'b1;
      if (in_ready) rdy_bad = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("sum_valid_pulse", sum_valid, 1);
    check("sum_data", sum_data, esum);
    check("busy_after_drain", busy, 0);
`ifdef SOFTMAX_SEQ_SAT_CNT_EN
    check("sat_cnt", sat_cnt, sat);
`endif
    check("sum_early", sv_early, 0);
    check("in_ready_drain", rdy_bad, 0);
    @(negedge clk);
    check("sum_valid_end", sum_valid, 0);
    check("sum_data_hold", sum_data, esum);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    tab[0] = '{n:3, stall:0, sat:0, din:'{17'h01000, 17'h02000, 17'h11000, 17'h0},
               ex:'{17'h11000, 17'h00000, 17'h13000, 17'h0}};
    tab[1] = '{n:2, stall:5, sat:1, din:'{17'h0A000, 17'h1A000, 17'h0, 17'h0},
               ex:'{17'h00000, 17'h1A000, 17'h0, 17'h0}};
    tab[2] = '{n:2, stall:0, sat:0, din:'{17'h10000, 17'h00000, 17'h0, 17'h0},
               ex:'{17'h00000, 17'h00000, 17'h0, 17'h0}};
    tab[3] = '{n:1, stall:2, sat:0, din:'{17'h05800, 17'h0, 17'h0, 17'h0},
               ex:'{17'h00000, 17'h0, 17'h0, 17'h0}};
    tab[4] = '{n:4, stall:0, sat:3, din:'{17'h1F000, 17'h1E000, 17'h1C800, 17'h11234},
               ex:'{17'h1A000, 17'h1A000, 17'h1A000, 17'h00000}};
    tab[5] = '{n:3, stall:1, sat:1, din:'{17'h0A001, 17'h00000, 17'h00001, 17'h0},
               ex:'{17'h00000, 17'h1A000, 17'h1A000, 17'h0}};
    tab[6] = '{n:2, stall:0, sat:0, din:'{17'h00800, 17'h07FFF, 17'h0, 17'h0},
               ex:'{17'h177FF, 17'h00000, 17'h0, 17'h0}};
    tab[7] = '{n:2, stall:0, sat:0, din:'{17'h00000, 17'h10000, 17'h0, 17'h0},
               ex:'{17'h00000, 17'h00000, 17'h0, 17'h0}};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_sum_data", sum_data, 0);
    check("rst_exp_x", exp_x, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_high", in_ready, 1);

    // Directed vector table
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < tab[k].n; j++) begin
        ex_x[j] = tab[k].ex[j];
        push(tab[k].din[j], (j == tab[k].n - 1));
      end
      check_issue(tab[k].n);
      drain_check(tab[k].n, tab[k].stall, tab[k].sat);
    end

    // Reset while a result is waiting in DRAIN
    push(17'h01000, 1'b0);
    push(17'h02000, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_drain_reached", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_drain_out_valid", out_valid, 0);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_sum_data", sum_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_drain_in_ready_low", in_ready, 0);
    @(negedge clk);
    ex_x[0] = 17'h00000;
    push(17'h01000, 1'b1);
    check_issue(1);
    drain_check(1, 0, 0);

    // Length limit: N_MAX elements without in_last, then one extra waiting
    for (int i = 0; i < N_MAX; i++) begin
      ex_x[i] = (i == N_MAX - 1) ? 17'h00000 : {1'b1, 16'((N_MAX - 1 - i) * 256)};
      push(17'(i * 256), 1'b0);
    end
    in_valid = 1'b1;
    in_data  = 17'h03000;
    in_last  = 1'b0;
    check_issue(N_MAX);
    drain_check(N_MAX, 0, 0);
    in_valid = 1'b0;
    check("extra_loaded_busy", busy, 1);
    ex_x[0] = 17'h00000;
    ex_x[1] = 17'h12000;
    push(17'h01000, 1'b1);
    check_issue(2);
    drain_check(2, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
